// File: rtl/regbank_pkg.sv
// Shared constants, scoreboard op encoding and port-slice helper for the
// forwarding register bank.
package regbank_pkg;

  localparam int unsigned REGBANK_DATA_W = 32;
  localparam int unsigned REGBANK_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR      = 0;

  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_CLEAR = 2'd1,
    SB_SET   = 2'd2
  } sb_op_e;

  // LSB of port 'port' inside a bus packed as NUM_RD fields of 'width' bits
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write busy bits: set by reserve, cleared by write or flush,
// with reserve winning over both on the same edge.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned ADDR_W = REGBANK_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     set_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic                     clr_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic                     flush_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  function automatic sb_op_e bit_op(input logic hit_set, input logic hit_clr);
    if (hit_set) return SB_SET;
    if (hit_clr) return SB_CLEAR;
    return SB_HOLD;
  endfunction

  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      case (bit_op(set_i && (set_addr_i == ADDR_W'(i)),
                   flush_i || (clr_i && (clr_addr_i == ADDR_W'(i)))))
        SB_SET:   busy_d[i] = 1'b1;
        SB_CLEAR: busy_d[i] = 1'b0;
        default:  busy_d[i] = busy_q[i];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    assign ra  = rd_addr_i[port_lsb(k, ADDR_W) +: ADDR_W];
    assign fwd = (BYPASS != 0) && clr_i && (clr_addr_i == ra);
    // A forwarded write shows post-edge busy: only a same-address reserve keeps it set
    assign rd_busy_o[k] = fwd ? (set_i && (set_addr_i == ra)) : busy_q[ra];
  end

endmodule

// File: rtl/regbank_fwd.sv
// Parametrised register bank with hardwired zero register, same-cycle
// write forwarding and a per-register pending-write scoreboard.
module regbank_fwd
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W   = REGBANK_DATA_W,
  parameter int unsigned ADDR_W   = REGBANK_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rAddr,
  output logic [NUM_RD*DATA_W-1:0] rData,
  output logic [NUM_RD-1:0]        rBusy,
  input  logic                     wEn,
  input  logic [ADDR_W-1:0]        wAddr,
  input  logic [DATA_W-1:0]        wData,
  input  logic                     resEn,
  input  logic [ADDR_W-1:0]        resAddr,
  input  logic                     flush
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA    = ADDR_W'(ZERO_ADDR);
  localparam logic              ZR_EN = (ZERO_REG != 0);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regbank_fwd: NUM_RD must be in 1..4");
  end

  logic              wr_ok;
  logic              res_ok;
  logic [NUM_RD-1:0] sb_busy;
  logic [DATA_W-1:0] regs_q [DEPTH];

  // Reset also masks the combinational forward path so outputs read zero
  assign wr_ok  = wEn   && !reset && !(ZR_EN && (wAddr   == ZA));
  assign res_ok = resEn && !reset && !(ZR_EN && (resAddr == ZA));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wAddr] <= wData;
    end
  end

  regbank_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_sb (
    .CLK        (CLK),
    .reset      (reset),
    .set_i      (res_ok),
    .set_addr_i (resAddr),
    .clr_i      (wr_ok),
    .clr_addr_i (wAddr),
    .flush_i    (flush),
    .rd_addr_i  (rAddr),
    .rd_busy_o  (sb_busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic [DATA_W-1:0] rd;
    assign ra      = rAddr[port_lsb(k, ADDR_W) +: ADDR_W];
    assign is_zero = ZR_EN && (ra == ZA);

    always_comb begin
      rd = regs_q[ra];
      if ((BYPASS != 0) && wr_ok && (wAddr == ra)) rd = wData;
      if (is_zero) rd = '0;
    end

    assign rData[port_lsb(k, DATA_W) +: DATA_W] = rd;
    assign rBusy[k] = sb_busy[k] && !is_zero;
  end

endmodule

// File: tb/tb_regbank_fwd.sv
// Directed-vector bench: default bank, a non-bypassing bank sharing its
// inputs, and a 4-port 64-bit 16-entry bank.
module tb_regbank_fwd;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  // Default bank (a_*) and BYPASS=0 bank (b_*) driven by the same inputs
  logic [9:0]  a_rAddr;
  logic [63:0] a_rData, b_rData;
  logic [1:0]  a_rBusy, b_rBusy;
  logic        a_wEn, a_resEn, a_flush;
  logic [4:0]  a_wAddr, a_resAddr;
  logic [31:0] a_wData;

  logic [15:0]  w_rAddr;
  logic [255:0] w_rData;
  logic [3:0]   w_rBusy;
  logic         w_wEn, w_resEn, w_flush;
  logic [3:0]   w_wAddr, w_resAddr;
  logic [63:0]  w_wData;

  regbank_fwd u_dut (
    .CLK(CLK), .reset(reset), .rAddr(a_rAddr), .rData(a_rData), .rBusy(a_rBusy),
    .wEn(a_wEn), .wAddr(a_wAddr), .wData(a_wData),
    .resEn(a_resEn), .resAddr(a_resAddr), .flush(a_flush)
  );

  regbank_fwd #(.BYPASS(0)) u_nobyp (
    .CLK(CLK), .reset(reset), .rAddr(a_rAddr), .rData(b_rData), .rBusy(b_rBusy),
    .wEn(a_wEn), .wAddr(a_wAddr), .wData(a_wData),
    .resEn(a_resEn), .resAddr(a_resAddr), .flush(a_flush)
  );

  regbank_fwd #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) u_wide (
    .CLK(CLK), .reset(reset), .rAddr(w_rAddr), .rData(w_rData), .rBusy(w_rBusy),
    .wEn(w_wEn), .wAddr(w_wAddr), .wData(w_wData),
    .resEn(w_resEn), .resAddr(w_resAddr), .flush(w_flush)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_idle();
    a_wEn = 1'b0; a_resEn = 1'b0; a_flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 1'b0;
    a_rAddr = '0;
    a_wEn = 1'b1; a_wAddr = 5'd5; a_wData = 32'hDEADBEEF;
    a_resEn = 1'b1; a_resAddr = 5'd5;
    w_wEn = 1'b0; w_wAddr = '0; w_wData = '0;
    w_resEn = 1'b0; w_resAddr = '0; w_flush = 1'b0; w_rAddr = '0;

    step();
    for (int i = 0; i < 32; i++) begin
      a_rAddr = {2{5'(i)}};
      #1;
      check($sformatf("rst_rd0_r%0d", i), 64'(a_rData[31:0]), 64'h0);
      check($sformatf("rst_rd1_r%0d", i), 64'(a_rData[63:32]), 64'h0);
      check($sformatf("rst_busy_r%0d", i), 64'(a_rBusy), 64'h0);
    end
    a_idle();
    reset = 1'b0;

    step();
    a_rAddr = {5'd5, 5'd5};
    #1;
    check("r5_after_rst_write", 64'(a_rData[31:0]), 64'h0);
    check("r5_after_rst_busy", 64'(a_rBusy), 64'h0);

    a_wEn = 1'b1; a_wAddr = 5'd7; a_wData = 32'h12345678; a_rAddr = {5'd0, 5'd7};
    #1;
    check("byp_same_cycle", 64'(a_rData[31:0]), 64'h12345678);
    check("nobyp_same_cycle", 64'(b_rData[31:0]), 64'h0);
    step();
    a_idle();
    #1;
    check("nobyp_next_cycle", 64'(b_rData[31:0]), 64'h12345678);
    check("byp_next_cycle", 64'(a_rData[31:0]), 64'h12345678);

    a_wEn = 1'b1; a_wAddr = 5'd0; a_wData = 32'hFFFFFFFF;
    a_resEn = 1'b1; a_resAddr = 5'd0; a_rAddr = {5'd0, 5'd0};
    #1;
    check("zero_rd0_same", 64'(a_rData[31:0]), 64'h0);
    check("zero_rd1_same", 64'(a_rData[63:32]), 64'h0);
    check("zero_busy_same", 64'(a_rBusy), 64'h0);
    step();
    a_idle();
    #1;
    check("zero_rd0_after", 64'(a_rData[31:0]), 64'h0);
    check("zero_rd1_after", 64'(a_rData[63:32]), 64'h0);
    check("zero_busy_after", 64'(a_rBusy), 64'h0);
    check("zero_nobyp_after", 64'(b_rData[31:0]), 64'h0);

    a_resEn = 1'b1; a_resAddr = 5'd9; a_rAddr = {5'd9, 5'd9};
    step();
    a_idle();
    #1;
    check("r9_reserved", 64'(a_rBusy), 64'h3);
    a_wEn = 1'b1; a_wAddr = 5'd9; a_wData = 32'h000000A5;
    #1;
    check("r9_wr_busy_fwd", 64'(a_rBusy[0]), 64'h0);
    check("r9_wr_data_fwd", 64'(a_rData[31:0]), 64'hA5);
    check("r9_nobyp_busy", 64'(b_rBusy[0]), 64'h1);
    check("r9_nobyp_data", 64'(b_rData[31:0]), 64'h0);
    step();
    a_idle();
    #1;
    check("r9_after_busy", 64'(a_rBusy[1]), 64'h0);
    check("r9_after_data", 64'(a_rData[63:32]), 64'hA5);

    a_wEn = 1'b1; a_wAddr = 5'd3; a_wData = 32'h00000033;
    a_resEn = 1'b1; a_resAddr = 5'd3; a_rAddr = {5'd3, 5'd3};
    #1;
    check("r3_wr_res_busy_fwd", 64'(a_rBusy[0]), 64'h1);
    check("r3_wr_res_data_fwd", 64'(a_rData[31:0]), 64'h33);
    step();
    a_idle();
    #1;
    check("r3_wr_res_busy", 64'(a_rBusy[0]), 64'h1);
    check("r3_wr_res_data", 64'(a_rData[31:0]), 64'h33);

    a_resEn = 1'b1; a_resAddr = 5'd2;
    step();
    a_resAddr = 5'd4;
    step();
    a_idle();
    a_rAddr = {5'd2, 5'd4};
    #1;
    check("pre_flush_busy", 64'(a_rBusy), 64'h3);
    a_flush = 1'b1; a_resEn = 1'b1; a_resAddr = 5'd4;
    step();
    a_idle();
    #1;
    check("flush_r4_busy", 64'(a_rBusy[0]), 64'h1);
    check("flush_r2_clear", 64'(a_rBusy[1]), 64'h0);
    a_rAddr = {5'd3, 5'd3};
    #1;
    check("flush_r3_clear", 64'(a_rBusy[0]), 64'h0);
    check("flush_r3_data", 64'(a_rData[31:0]), 64'h33);

    a_resEn = 1'b1; a_resAddr = 5'd7; a_rAddr = {5'd9, 5'd7};
    step();
    a_idle();
    #2;
    check("pre_async_busy", 64'(a_rBusy[0]), 64'h1);
    reset = 1'b1;
    #1;
    check("async_rst_rd0", 64'(a_rData[31:0]), 64'h0);
    check("async_rst_rd1", 64'(a_rData[63:32]), 64'h0);
    check("async_rst_busy", 64'(a_rBusy), 64'h0);
    reset = 1'b0;
    step();

    w_wEn = 1'b1; w_wAddr = 4'd15; w_wData = 64'h0123456789ABCDEF;
    w_rAddr = {4{4'hF}};
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("wide_fwd_p%0d", k), w_rData[k*64 +: 64], 64'h0123456789ABCDEF);
    step();
    w_wEn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("wide_stored_p%0d", k), w_rData[k*64 +: 64], 64'h0123456789ABCDEF);
    check("wide_busy", 64'(w_rBusy), 64'h0);
    w_rAddr = {4'd0, 4'd14, 4'd1, 4'd15};
    #1;
    check("wide_r14_empty", w_rData[128 +: 64], 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regbank_fwd.md
# regbank_fwd

Parametrised register bank for the MIPS datapath: configurable data width, depth and number of read ports, with a hardwired zero register, same-cycle write-to-read forwarding and a per-register pending-write scoreboard. It replaces the fixed 2-read/1-write 32×32 bank in the decode stage. Issue logic uses the scoreboard to detect RAW hazards on multi-cycle producers such as loads and mul/div.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
- BYPASS, 1, 1 = write data forwarded to same-cycle reads

- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- rAddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rData  out  NUM_RD*DATA_W  read data, packed the same way
- rBusy  out  NUM_RD  per-port: addressed register has an outstanding reservation
- wEn  in  1  write enable
- wAddr  in  ADDR_W  write address
- wData  in  DATA_W  write data
- resEn  in  1  reserve: mark resAddr as pending
- resAddr  in  ADDR_W  register being reserved
- flush  in  1  clear all reservations (pipeline squash)

## Operation
- Storage: 2**ADDR_W × DATA_W registers, plus 2**ADDR_W busy bits.
- Reset (async): all registers become 0 and all busy bits become 0. rData and rBusy then reflect zeros.
- Write: on a CLK rising edge with wEn=1 and reset=0, the register at wAddr takes wData, and busy[wAddr] is cleared.
- Reserve: on a rising edge with resEn=1, busy[resAddr] is set.
- Same-edge write and reserve to one address: the register is written and busy stays 1, because the reserving producer is newer.
- flush=1: all busy bits clear on the edge. A reserve in the same cycle is still applied (flush then reserve). Register contents are unaffected.
- ZERO_REG=1 and address 0:
  - reads return 0 and rBusy=0;
  - writes and reserves to address 0 are dropped.
- Read ports are combinational and independent. Any number of ports may address the same register.
- Forwarding when BYPASS=1: if wEn=1 and wAddr==rAddr[k] (and the address is not a dropped zero-reg address), then rData[k]=wData in the same cycle. In that case rBusy[k] reflects busy after the write, i.e. 0 unless resEn targets the same address this cycle.
- Reads when BYPASS=0: rData and rBusy reflect the stored state only, so a written value is visible from the cycle after the edge.
- Out-of-range parameters (NUM_RD<1 or NUM_RD>4) are flagged with an elaboration-time error.

## Timing
- Read latency 0 (combinational from rAddr, wEn, wAddr, wData, resEn, resAddr).
- Write, reserve and flush take effect on the rising edge. Stored state is visible after 1 edge.
- Reset asserted mid-cycle clears state immediately, regardless of CLK. Writes and reserves in a cycle with reset=1 are discarded.
- Reset deassertion is synchronised externally. The first write is accepted on the first edge with reset=0.
- No backpressure: writes and reserves are always accepted.

## Structure
- Package regbank_pkg holds:
  - default constants REGBANK_DATA_W=32 and REGBANK_ADDR_W=5;
  - ZERO_ADDR;
  - a function that packs/unpacks a port index into its bit slice.
- Sub-module regbank_scoreboard contains the busy-bit array, with the set/clear/flush priority logic and the per-port rBusy muxing.
- The top level holds the data array, the zero-register gating and the bypass muxes.

## Test plan
- Reset then read: assert reset, read all addresses on both ports -> rData=0, rBusy=0. Write 0xDEADBEEF to r5 during reset -> r5 still reads 0 afterwards.
- Write/readback and bypass (BYPASS=1): wEn=1, wAddr=7, wData=0x12345678, rAddr0=7 -> rData0=0x12345678 in the same cycle. With BYPASS=0 the same stimulus gives the old value (0), and 0x12345678 from the next cycle.
- Zero register: write 0xFFFFFFFF to r0, reserve r0 -> r0 reads 0 and rBusy=0 on all ports, both in the same cycle and afterwards.
- Scoreboard: reserve r9 -> rBusy=1 for r9 from the next cycle. Write r9=0xA5 -> the port reading r9 shows rBusy=0 and data 0xA5 in the write cycle.
- Simultaneous events:
  - reserve and write r3 on the same edge -> r3 holds the new data and busy=1;
  - flush and reserve r4 on the same edge while r2 and r4 are busy -> only r4 busy afterwards.
- Parametric: NUM_RD=4, DATA_W=64, ADDR_W=4 -> write 0x0123456789ABCDEF to r15 -> all four ports addressing r15 return it; r16 is not addressable.
